// File: rtl/seg7_scan_capture_if.sv
// Display-bus and frame-handshake bundle for seg7_scan_capture.
// master: the capture block (reads the display bus, offers frames).
// slave:  the environment (drives the display bus, consumes frames).
interface seg7_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [0:6]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   err_mask;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overrun;

  modport master (
    input  seg, an, frame_ready,
    output digits, blank_mask, err_mask, frame_valid, overrun
  );

  modport slave (
    output seg, an, frame_ready,
    input  digits, blank_mask, err_mask, frame_valid, overrun
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus and
// presents each complete frame on a valid/ready handshake.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seg7_scan_capture_if.master bus
);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {COLLECT, PRESENT} state_t;

  // Decoded segment pattern: code plus blank/err flags.
  typedef struct packed {
    logic       blank;
    logic       err;
    logic [3:0] code;
  } dec_t;

  function automatic dec_t decode(input logic [0:6] s);
    case (s)
      7'b0000001: decode = '{1'b0, 1'b0, 4'd0};
      7'b1001111: decode = '{1'b0, 1'b0, 4'd1};
      7'b0010010: decode = '{1'b0, 1'b0, 4'd2};
      7'b0000110: decode = '{1'b0, 1'b0, 4'd3};
      7'b1001100: decode = '{1'b0, 1'b0, 4'd4};
      7'b0100100: decode = '{1'b0, 1'b0, 4'd5};
      7'b0100000: decode = '{1'b0, 1'b0, 4'd6};
      7'b0001111: decode = '{1'b0, 1'b0, 4'd7};
      7'b0000000: decode = '{1'b0, 1'b0, 4'd8};
      7'b0000100: decode = '{1'b0, 1'b0, 4'd9};
      7'b1111111: decode = '{1'b1, 1'b0, 4'hF};
      default:    decode = '{1'b0, 1'b1, 4'hE};
    endcase
  endfunction

  logic [0:6]              seg_m, seg_s, seg_p;
  logic [NUM_DIGITS-1:0]   an_m, an_s, an_p;
  logic [7:0]              cnt, cnt_next;
  logic [SW-1:0]           slot;
  logic                    capture, complete;
  dec_t                    dec;
  logic [NUM_DIGITS-1:0]   seen, seen_next;
  logic [4*NUM_DIGITS-1:0] work_digits, work_digits_next;
  logic [NUM_DIGITS-1:0]   work_blank, work_blank_next;
  logic [NUM_DIGITS-1:0]   work_err, work_err_next;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   blank_q, err_q;
  logic                    frame_valid_q, overrun_q;

  // Two-flop synchronizers plus the previous-sample register; idle = all ones.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source regardless of statement order.
    if (rst) begin
      seg_m <= '1; seg_s <= '1; seg_p <= '1;
      an_m  <= '1; an_s  <= '1; an_p  <= '1;
    end else begin
      seg_m <= bus.seg; seg_s <= seg_m; seg_p <= seg_s;
      an_m  <= bus.an;  an_s  <= an_m;  an_p  <= an_s;
    end
  end

  // Stability count, capture strobe, slot index and next working frame.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    cnt_next         = cnt;
    slot             = '0;
    capture          = 1'b0;
    dec              = decode(seg_s);
    work_digits_next = work_digits;
    work_blank_next  = work_blank;
    work_err_next    = work_err;
    seen_next        = seen;

    if ({an_s, seg_s} != {an_p, seg_p}) cnt_next = 8'd1;
    else if (cnt < STABLE)              cnt_next = cnt + 8'd1;

    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_s[i]) slot = SW'(i);

    // Strobe only on the transition into STABLE, and only with one anode low.
    capture = $onehot(~an_s) && (cnt_next == STABLE) && (cnt != STABLE);

    if (capture) begin
      work_digits_next[4*slot +: 4] = dec.code;
      work_blank_next[slot]         = dec.blank;
      work_err_next[slot]           = dec.err;
      seen_next[slot]               = 1'b1;
    end
    complete = capture && (&seen_next);
  end

  // Stability counter, seen mask and working frame registers.
  always_ff @(posedge clk) begin
    // NOTE: the working frame is a handful of flops, so it is reset explicitly
    // and a partial frame after reset never carries stale digits.
    if (rst) begin
      cnt         <= '0;
      seen        <= '0;
      work_digits <= '0;
      work_blank  <= '0;
      work_err    <= '0;
    end else begin
      cnt         <= cnt_next;
      seen        <= complete ? '0 : seen_next;
      work_digits <= work_digits_next;
      work_blank  <= work_blank_next;
      work_err    <= work_err_next;
    end
  end

  // Frame FSM: load completed frames, hold until accepted, flag drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      digits_q      <= '0;
      blank_q       <= '0;
      err_q         <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (complete) begin
            digits_q      <= work_digits_next;
            blank_q       <= work_blank_next;
            err_q         <= work_err_next;
            frame_valid_q <= 1'b1;
            state         <= PRESENT;
          end
        end
        PRESENT: begin
          if (complete) begin
            if (bus.frame_ready) begin
              digits_q <= work_digits_next;
              blank_q  <= work_blank_next;
              err_q    <= work_err_next;
            end else begin
              overrun_q <= 1'b1;
            end
          end else if (bus.frame_ready) begin
            frame_valid_q <= 1'b0;
            state         <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.digits      = digits_q;
  assign bus.blank_mask  = blank_q;
  assign bus.err_mask    = err_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
// Inputs change 1 ns after a rising edge; outputs are read at that point.
module tb_seg7_scan_capture;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [0:6] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [0:6] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [0:6] S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000;
  localparam logic [0:6] S9 = 7'b0000100, SB = 7'b1111111, SE = 7'b1110000;

  seg7_scan_capture_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one digit for 'cycles' clocks, then 2 clocks of inter-digit blanking.
  task automatic show(input int idx, input logic [0:6] pat, input int cycles);
    logic [3:0] sel;
    sel = 4'b0001 << idx;
    bus.an  = ~sel;
    bus.seg = pat;
    tick(cycles);
    bus.an = 4'hF;
    tick(2);
  endtask

  task automatic show_frame(input logic [0:6] p0, input logic [0:6] p1,
                            input logic [0:6] p2, input logic [0:6] p3);
    show(0, p0, 8);
    show(1, p1, 8);
    show(2, p2, 8);
    show(3, p3, 8);
  endtask

  task automatic accept();
    bus.frame_ready = 1'b1;
    tick(1);
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.seg = 7'($urandom);
      bus.an  = 4'($urandom);
      tick(1);
    end
    n_checks++; if (bus.digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits got %h want 0000", bus.digits); end
    n_checks++; if (bus.blank_mask !== 4'h0) begin n_fail++; $display("FAIL reset_blank got %b want 0000", bus.blank_mask); end
    n_checks++; if (bus.err_mask !== 4'h0) begin n_fail++; $display("FAIL reset_err got %b want 0000", bus.err_mask); end
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.frame_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    rst     = 1'b0;
    bus.an  = 4'hF;
    bus.seg = S8;
    tick(6 + 4);
    n_checks++; if (dut.seen !== 4'b0000) begin n_fail++; $display("FAIL idle_seen got %b want 0000", dut.seen); end
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", bus.frame_valid); end
  endtask

  task automatic test_basic_frame();
    show_frame(S3, S4, S7, S0);
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.frame_valid); end
    n_checks++; if (bus.digits !== 16'h0743) begin n_fail++; $display("FAIL basic_digits got %h want 0743", bus.digits); end
    n_checks++; if (bus.blank_mask !== 4'b0000) begin n_fail++; $display("FAIL basic_blank got %b want 0000", bus.blank_mask); end
    n_checks++; if (bus.err_mask !== 4'b0000) begin n_fail++; $display("FAIL basic_err got %b want 0000", bus.err_mask); end
    tick(5);
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold got %b want 1", bus.frame_valid); end
    accept();
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept got %b want 0", bus.frame_valid); end
    n_checks++; if (bus.digits !== 16'h0743) begin n_fail++; $display("FAIL basic_held_data got %h want 0743", bus.digits); end
  endtask

  task automatic test_blank_err();
    show_frame(S0, SB, SE, S1);
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL be_valid got %b want 1", bus.frame_valid); end
    n_checks++; if (bus.digits !== 16'h1EF0) begin n_fail++; $display("FAIL be_digits got %h want 1ef0", bus.digits); end
    n_checks++; if (bus.blank_mask !== 4'b0010) begin n_fail++; $display("FAIL be_blank got %b want 0010", bus.blank_mask); end
    n_checks++; if (bus.err_mask !== 4'b0100) begin n_fail++; $display("FAIL be_err got %b want 0100", bus.err_mask); end
    accept();
  endtask

  task automatic test_filter();
    show(3, S9, 8);
    n_checks++; if (dut.seen !== 4'b1000) begin n_fail++; $display("FAIL filt_pre_seen got %b want 1000", dut.seen); end
    show(0, S8, 3);
    bus.an  = 4'b0101;
    bus.seg = S8;
    tick(10);
    bus.an = 4'hF;
    tick(2);
    n_checks++; if (dut.seen !== 4'b1000) begin n_fail++; $display("FAIL filt_seen got %b want 1000", dut.seen); end
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL filt_valid got %b want 0", bus.frame_valid); end
    show(0, S5, 8);
    show(1, S6, 8);
    show(2, S2, 8);
    n_checks++; if (bus.digits !== 16'h9265) begin n_fail++; $display("FAIL filt_digits got %h want 9265", bus.digits); end
    accept();
  endtask

  task automatic test_handshake();
    bus.frame_ready = 1'b0;
    show_frame(S1, S2, S3, S4);
    n_checks++; if (bus.digits !== 16'h4321) begin n_fail++; $display("FAIL hs_first got %h want 4321", bus.digits); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL hs_no_overrun got %b want 0", bus.overrun); end
    show_frame(S5, S6, S7, S8);
    n_checks++; if (bus.digits !== 16'h4321) begin n_fail++; $display("FAIL hs_dropped got %h want 4321", bus.digits); end
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL hs_overrun got %b want 1", bus.overrun); end
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL hs_valid_held got %b want 1", bus.frame_valid); end
    show(0, S9, 8);
    show(1, S8, 8);
    show(2, S0, 8);
    // Last digit captures on the 6th edge after the pins change; accept on it.
    bus.an  = 4'b0111;
    bus.seg = S1;
    tick(5);
    bus.frame_ready = 1'b1;
    tick(1);
    bus.frame_ready = 1'b0;
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL hs_coinc_valid got %b want 1", bus.frame_valid); end
    n_checks++; if (bus.digits !== 16'h1089) begin n_fail++; $display("FAIL hs_coinc_digits got %h want 1089", bus.digits); end
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL hs_sticky got %b want 1", bus.overrun); end
    tick(2);
    bus.an = 4'hF;
    tick(2);
    accept();
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL hs_final_accept got %b want 0", bus.frame_valid); end
  endtask

  task automatic test_reset_mid();
    show(2, S2, 8);
    show(3, S3, 8);
    n_checks++; if (dut.seen !== 4'b1100) begin n_fail++; $display("FAIL rm_pre_seen got %b want 1100", dut.seen); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++; if (dut.seen !== 4'b0000) begin n_fail++; $display("FAIL rm_seen got %b want 0000", dut.seen); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rm_overrun got %b want 0", bus.overrun); end
    n_checks++; if (bus.digits !== 16'h0000) begin n_fail++; $display("FAIL rm_digits got %h want 0000", bus.digits); end
    show(0, S6, 8);
    show(1, S7, 8);
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL rm_partial_valid got %b want 0", bus.frame_valid); end
    show(2, S8, 8);
    show(3, S9, 8);
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL rm_full_valid got %b want 1", bus.frame_valid); end
    n_checks++; if (bus.digits !== 16'h9876) begin n_fail++; $display("FAIL rm_digits_full got %h want 9876", bus.digits); end
  endtask

  initial begin
    rst             = 1'b1;
    bus.seg         = '1;
    bus.an          = '1;
    bus.frame_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_blank_err();
    test_filter();
    test_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment display drivers.
- Monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and recovers a BCD value for every digit position.
- Presents each completed frame of digits on a valid/ready handshake, with blank and error flags per digit.
- Used for loopback self-test of the display path and for observing display output in system benches.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (anode lines); 1..8.
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured; 2..255.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
seg  input  [0:6]  active-low segments; seg[0]=a ... seg[6]=g.
an  input  [NUM_DIGITS-1:0]  active-low digit selects; an[i]=0 means digit i is driven.
digits  output  [4*NUM_DIGITS-1:0]  recovered codes; digit i occupies bits [4i+3:4i].
blank_mask  output  [NUM_DIGITS-1:0]  bit i set means digit i was blank (seg=1111111).
err_mask  output  [NUM_DIGITS-1:0]  bit i set means digit i held an undecodable pattern.
frame_valid  output  1  frame available; held until accepted.
frame_ready  input  1  consumer accepts the frame when frame_valid && frame_ready.
overrun  output  1  sticky; a completed frame was dropped because the previous frame was not yet accepted.

Behaviour:
- Input synchronization:
  - seg and an each pass through a 2-flop synchronizer.
  - All later logic uses the synchronized values (seg_s, an_s).
  - Synchronizer flops reset to all-ones (no anode driven, blank), so reset causes no false capture.
- Stability counter:
  - Compare {an_s, seg_s} with the previous cycle's value.
  - If different: cnt <= 1.
  - If equal: cnt increments, saturating at STABLE_CYCLES.
- Capture strobe:
  - Fires for exactly one cycle, on the cycle where cnt becomes STABLE_CYCLES.
  - Fires only if an_s has exactly one bit low. Index i is the position of that low bit.
  - If an_s is all-ones (inter-digit blanking) or has more than one bit low (ghosting), no capture occurs; the counter still runs.
  - A held-stable pattern captures once only. It must change and re-stabilize before it captures again.
- Decode of seg_s (a..g order, 0 = lit):
  - 0000001 -> 0; 1001111 -> 1; 0010010 -> 2; 0000110 -> 3; 1001100 -> 4.
  - 0100100 -> 5; 0100000 -> 6; 0001111 -> 7; 0000000 -> 8; 0000100 -> 9.
  - 1111111 -> code 4'hF, blank flag = 1.
  - Any other pattern -> code 4'hE, err flag = 1.
  - A decoded value clears the other flag for that slot.
- Working frame:
  - A capture into slot i writes a working register for code, blank and err, and sets seen[i].
  - A re-capture of an already-seen slot overwrites it (latest value wins).
- Frame state machine, COLLECT <-> PRESENT:
  - Frame completes on the capture that makes seen all-ones. seen clears on that same edge.
  - On completion with frame_valid=0: copy the working registers to digits, blank_mask and err_mask. frame_valid=1 from the next cycle.
  - On completion with frame_valid=1 and frame_ready=0: the new frame is dropped, output registers are unchanged, overrun <= 1.
  - On completion in the same cycle as an accept (valid && ready): outputs load the new frame and frame_valid stays 1. No overrun.
  - On accept with no completion: frame_valid <= 0. Output data is held (not cleared).
  - overrun clears only on rst.
- Reset:
  - Synchronous; has priority over all other events, including mid-capture and mid-handshake.
  - Values after reset: digits=0, blank_mask=0, err_mask=0, frame_valid=0, overrun=0, cnt=0, seen=0, working registers=0, synchronizers all-ones.
- Latency: a pattern stable at the pins from edge t captures at edge t+1+STABLE_CYCLES (2 sync stages + counting). With STABLE_CYCLES=4, pins must hold at least 6 cycles for a guaranteed capture.

Test Plan:
1. Reset state: hold rst 3 cycles with random seg/an -> all outputs 0; no capture for STABLE_CYCLES+2 cycles after release with an=1111.
2. Basic frame (defaults): drive digit0=0000110, digit1=1001100, digit2=0001111, digit3=0000001, each 8 cycles with 2 cycles of an=1111 between -> one frame, digits=16'h0743, blank_mask=0, err_mask=0; frame_valid high until ready pulses.
3. Blank/error: digit1 seg=1111111, digit2 seg=1110000 -> digits=16'h?EF? (slot1=F, slot2=E), blank_mask=0010, err_mask=0100.
4. Stability filter: digit0 pattern held 3 cycles at pins, then changed; an=0101 (two low) held 10 cycles -> neither produces a capture; seen unchanged.
5. Handshake: hold frame_ready=0 across two complete frames -> first frame held, overrun=1. Next completion coincident with a ready pulse -> new data loaded, frame_valid stays 1.
6. Reset mid-frame: rst asserted after 2 of 4 digits captured -> seen cleared; the next frame requires all 4 digits afresh.
